// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte producers (round-robin by default).
// Define UART_ARB_FIXED_PRIO_EN to select fixed priority (lowest requesting index always wins).
module uart_tx_arbiter #(
    parameter int          NUM_REQ      = 4,
    parameter logic [7:0]  BAUD_DIV     = 8'd16,
    parameter logic [15:0] FRAME_CYCLES = 16'd2720
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [1:0]           address,
    output logic [7:0]           w_data,
    output logic                 write,
    output logic                 read,
    output logic                 busy,
    output logic [2:0]           grant_id
);

    typedef enum logic [2:0] {
        S_INIT_BD,
        S_IDLE,
        S_LOAD,
        S_ENABLE,
        S_WAIT,
        S_DISABLE
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           last_q, last_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [1:0]           address_q, address_d;
    logic [7:0]           w_data_q, w_data_d;
    logic                 write_q, write_d;
    logic                 busy_q, busy_d;
    logic [2:0]           grant_id_q, grant_id_d;

    logic [7:0]           req_byte [8];
    logic [NUM_REQ-1:0]   rot;
    logic [3:0]           start;
    logic [3:0]           off;
    logic [3:0]           sum;
    logic [2:0]           win;
    logic                 found;

    // Pad the byte table to 8 entries so a 3-bit winner index always fits.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_byte
            if (gi < NUM_REQ) begin : g_real
                assign req_byte[gi] = req_data[8*gi +: 8];
            end else begin : g_pad
                assign req_byte[gi] = 8'h00;
            end
        end
    endgenerate

    // Rotate requests so the search starts at last+1, then take the lowest set bit.
    always_comb begin
`ifdef UART_ARB_FIXED_PRIO_EN
        start = 4'd0;
        rot   = req_valid;
`else
        start = {1'b0, last_q} + 4'd1;
        rot   = NUM_REQ'({req_valid, req_valid} >> start);
`endif
        off = 4'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = 4'(k);
        end
        found = |rot;
        sum   = start + off;
        win   = 3'((sum >= 4'(NUM_REQ)) ? sum - 4'(NUM_REQ) : sum);
    end

    // Outputs are computed for the state being entered, so each access lands on its own cycle.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        req_ready_d = '0;
        address_d   = address_q;
        w_data_d    = w_data_q;
        write_d     = 1'b0;
        busy_d      = busy_q;
        grant_id_d  = grant_id_q;
        case (state_q)
            S_INIT_BD: begin
                address_d = 2'b00;
                w_data_d  = BAUD_DIV;
                write_d   = 1'b1;
                state_d   = S_IDLE;
            end
            S_IDLE: begin
                if (found) begin
                    state_d     = S_LOAD;
                    address_d   = 2'b10;
                    w_data_d    = req_byte[win];
                    write_d     = 1'b1;
                    req_ready_d = NUM_REQ'(1) << win;
                    busy_d      = 1'b1;
                    grant_id_d  = win;
`ifndef UART_ARB_FIXED_PRIO_EN
                    last_d      = win;
`endif
                end
            end
            S_LOAD: begin
                state_d   = S_ENABLE;
                address_d = 2'b01;
                w_data_d  = 8'h01;
                write_d   = 1'b1;
                cnt_d     = FRAME_CYCLES - 16'd1;
            end
            S_ENABLE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 16'd0) begin
                    state_d   = S_DISABLE;
                    address_d = 2'b01;
                    w_data_d  = 8'h00;
                    write_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DISABLE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_INIT_BD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_INIT_BD;
            last_q      <= 3'(NUM_REQ - 1);
            cnt_q       <= 16'd0;
            req_ready_q <= '0;
            address_q   <= 2'b00;
            w_data_q    <= 8'h00;
            write_q     <= 1'b0;
            busy_q      <= 1'b0;
            grant_id_q  <= 3'd0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            address_q   <= address_d;
            w_data_q    <= w_data_d;
            write_q     <= write_d;
            busy_q      <= busy_d;
            grant_id_q  <= grant_id_d;
        end
    end

    assign req_ready = req_ready_q;
    assign address   = address_q;
    assign w_data    = w_data_q;
    assign write     = write_q;
    assign read      = 1'b0;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;

endmodule
